// File: rtl/mod_issue_pkg.sv
// Shared defaults and helpers for the mod_issue operand queue and modulus unit.
package mod_issue_pkg;

  localparam int DATAWIDTH_DEF = 16;
  localparam int DEPTH_DEF     = 4;
  localparam logic [7:0] DZ_SAT = 8'd255;

  // Number of bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mod_issue_mod.sv
// Purely combinational unsigned remainder; the caller guarantees a nonzero divisor.
module mod_issue_mod
  import mod_issue_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic [DATAWIDTH-1:0] dividend_i,
  input  logic [DATAWIDTH-1:0] divisor_i,
  output logic [DATAWIDTH-1:0] remainder_o
);

  assign remainder_o = dividend_i % divisor_i;

endmodule

// File: rtl/mod_issue.sv
// Operand FIFO feeding a remainder unit, with a registered result stage and a
// saturating divide-by-zero delivery counter.
module mod_issue
  import mod_issue_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATAWIDTH-1:0]  in_a,
  input  logic [DATAWIDTH-1:0]  in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATAWIDTH-1:0]  out_rem,
  output logic                  out_dz,
  output logic [clog2(DEPTH):0] count,
  output logic [7:0]            dz_total
);

  localparam int PW = clog2(DEPTH);
  localparam logic [PW:0]          DEPTH_C  = (PW+1)'(DEPTH);
  localparam logic [PW:0]          CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
  localparam logic [DATAWIDTH-1:0] DATA_ONE = DATAWIDTH'(1);
  localparam logic [DATAWIDTH-1:0] DATA_ZERO = DATAWIDTH'(0);

  logic [DATAWIDTH-1:0] a_mem_q [DEPTH];
  logic [DATAWIDTH-1:0] b_mem_q [DEPTH];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW:0]          count_q, count_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATAWIDTH-1:0] out_rem_q, out_rem_d;
  logic                 out_dz_q, out_dz_d;
  logic [7:0]           dz_total_q, dz_total_d;

  logic                 push_s;
  logic                 pop_s;
  logic [DATAWIDTH-1:0] head_a_s;
  logic [DATAWIDTH-1:0] head_b_s;
  logic                 head_dz_s;
  logic [DATAWIDTH-1:0] div_b_s;
  logic [DATAWIDTH-1:0] mod_rem_s;
  logic [DATAWIDTH-1:0] head_rem_s;

  assign in_ready  = (count_q < DEPTH_C);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = (count_q != '0) && (!out_valid_q || out_ready);

  assign head_a_s  = a_mem_q[rd_ptr_q];
  assign head_b_s  = b_mem_q[rd_ptr_q];
  assign head_dz_s = (head_b_s == DATA_ZERO);
  // A zero divisor is replaced by one so the divider never sees it; the result is muxed below.
  assign div_b_s    = head_dz_s ? DATA_ONE : head_b_s;
  assign head_rem_s = head_dz_s ? head_a_s : mod_rem_s;

  mod_issue_mod #(
    .DATAWIDTH (DATAWIDTH)
  ) u_mod (
    .dividend_i  (head_a_s),
    .divisor_i   (div_b_s),
    .remainder_o (mod_rem_s)
  );

  // Queue storage write port; contents are don't-care until pointed at.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      a_mem_q[wr_ptr_q] <= in_a;
      b_mem_q[wr_ptr_q] <= in_b;
    end
  end

  // Next-state for pointers, occupancy, result register and dz counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_rem_d   = out_rem_q;
    out_dz_d    = out_dz_q;
    dz_total_d  = dz_total_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (pop_s) begin
      out_valid_d = 1'b1;
      out_rem_d   = head_rem_s;
      out_dz_d    = head_dz_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (out_valid_q && out_ready && out_dz_q && (dz_total_q != DZ_SAT)) begin
      dz_total_d = dz_total_q + 8'd1;
    end else begin
      dz_total_d = dz_total_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_rem_q   <= '0;
      out_dz_q    <= 1'b0;
      dz_total_q  <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_rem_q   <= out_rem_d;
      out_dz_q    <= out_dz_d;
      dz_total_q  <= dz_total_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rem   = out_rem_q;
  assign out_dz    = out_dz_q;
  assign count     = count_q;
  assign dz_total  = dz_total_q;

endmodule

// File: tb/tb_mod_issue.sv
// Directed bench for mod_issue with a queue-based reference model checked every cycle.
module tb_mod_issue;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          Clk;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_rem;
  logic          out_dz;
  logic [2:0]    count;
  logic [7:0]    dz_total;

  int checks = 0;
  int errors = 0;

  mod_issue #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rem   (out_rem),
    .out_dz    (out_dz),
    .count     (count),
    .dz_total  (dz_total)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: pending results in acceptance order plus one output slot.
  typedef struct packed {
    logic [DW-1:0] rem;
    logic          dz;
  } res_t;

  function automatic res_t model_res(input logic [DW-1:0] a, input logic [DW-1:0] b);
    res_t r;
    if (b == 16'd0) begin
      r.rem = a;
      r.dz  = 1'b1;
    end else begin
      r.rem = a % b;
      r.dz  = 1'b0;
    end
    return r;
  endfunction

  res_t          mq[$];
  logic          m_valid;
  logic [DW-1:0] m_rem;
  logic          m_dz;
  int            m_dzt;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mq.delete();
      m_valid = 1'b0;
      m_rem   = '0;
      m_dz    = 1'b0;
      m_dzt   = 0;
    end else begin
      bit   take, acc, ld;
      res_t r;
      take = m_valid && out_ready;
      acc  = in_valid && (mq.size() < DEPTH);
      ld   = (mq.size() > 0) && (!m_valid || out_ready);
      if (take && m_dz && m_dzt < 255) m_dzt++;
      if (ld) begin
        r       = mq.pop_front();
        m_valid = 1'b1;
        m_rem   = r.rem;
        m_dz    = r.dz;
      end else if (take) begin
        m_valid = 1'b0;
      end
      if (acc) mq.push_back(model_res(in_a, in_b));
    end
  end

  always @(negedge Clk) begin
    if (Rst) begin
      chk("count",     32'(count),     32'(mq.size()));
      chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_rem",   32'(out_rem),   32'(m_rem));
      chk("out_dz",    32'(out_dz),    32'(m_dz));
      chk("dz_total",  32'(dz_total),  32'(m_dzt));
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n, delivered, accepted, maxcnt;
    bit full_seen, empty_seen;
    logic [DW-1:0] got [8];
    logic [DW-1:0] exp_bp [5];
    exp_bp = '{16'd1, 16'd2, 16'd0, 16'd1, 16'd2};

    Rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    #2;
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dz_total",  32'(dz_total),  32'd0);
    chk("rst_out_rem",   32'(out_rem),   32'd0);
    #10;
    Rst = 1'b1;
    step();

    // Single pair 100 % 7
    in_valid = 1'b1; in_a = 16'd100; in_b = 16'd7; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_fill_valid", 32'(out_valid), 32'd0);
    chk("single_fill_count", 32'(count),     32'd1);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_rem",   32'(out_rem),   32'd2);
    chk("single_dz",    32'(out_dz),    32'd0);
    step();
    chk("single_drop",     32'(out_valid), 32'd0);
    chk("single_rem_keep", 32'(out_rem),   32'd2);

    // Backpressure: five pairs against a stalled consumer
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 16'(10 + i); in_b = 16'd3;
      step();
    end
    chk("bp_valid",    32'(out_valid), 32'd1);
    chk("bp_rem",      32'(out_rem),   32'd1);
    chk("bp_count",    32'(count),     32'd4);
    chk("bp_in_ready", 32'(in_ready),  32'd0);
    in_a = 16'd99;
    step();
    chk("bp_full_count", 32'(count),   32'd4);
    chk("bp_hold_rem",   32'(out_rem), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid && n < 8) begin
        got[n] = out_rem;
        n++;
      end
      step();
    end
    chk("bp_n", 32'(n), 32'd5);
    for (int i = 0; i < 5; i++) chk("bp_order", 32'(got[i]), 32'(exp_bp[i]));

    // Divide by zero and saturation
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'd0;
    step();
    in_valid = 1'b0;
    step();
    chk("dz_valid", 32'(out_valid), 32'd1);
    chk("dz_rem",   32'(out_rem),   32'h1234);
    chk("dz_flag",  32'(out_dz),    32'd1);
    step();
    chk("dz_total_one", 32'(dz_total), 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 299; i++) step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("dz_total_sat", 32'(dz_total), 32'd255);

    // Streaming at full rate
    delivered = 0; maxcnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 53; i++) begin
      in_valid = (i < 50);
      in_a = 16'($urandom);
      in_b = (i % 10 == 3) ? 16'd0 : 16'($urandom_range(1, 65535));
      if (i == 2) chk("stream_fill", 32'(out_valid), 32'd1);
      if (32'(count) > maxcnt) maxcnt = 32'(count);
      if (out_valid && out_ready) delivered++;
      step();
    end
    chk("stream_delivered", 32'(delivered), 32'd50);
    chk("stream_maxcnt_le1", 32'(maxcnt <= 1), 32'd1);

    // Pointer wrap with stalls
    accepted = 0; delivered = 0; full_seen = 1'b0; empty_seen = 1'b0;
    for (int k = 0; k < 400 && delivered < 3*DEPTH; k++) begin
      out_ready = (k < 6) ? 1'b0 : ($urandom_range(0, 3) != 0);
      in_valid  = (accepted < 3*DEPTH) && ((k < 6) || ($urandom_range(0, 1) == 1));
      in_a = 16'($urandom);
      in_b = 16'($urandom_range(1, 300));
      if (count == 3'd4) full_seen = 1'b1;
      if (accepted > 0 && count == 3'd0 && !out_valid) empty_seen = 1'b1;
      if (in_valid && in_ready) accepted++;
      if (out_valid && out_ready) delivered++;
      step();
    end
    in_valid = 1'b0;
    step();
    if (count == 3'd0 && !out_valid) empty_seen = 1'b1;
    chk("wrap_accepted",  32'(accepted),   32'(3*DEPTH));
    chk("wrap_delivered", 32'(delivered),  32'(3*DEPTH));
    chk("wrap_full",      32'(full_seen),  32'd1);
    chk("wrap_empty",     32'(empty_seen), 32'd1);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 16'(50 + i); in_b = 16'd6;
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count),     32'd3);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    Rst = 1'b0;
    #1;
    chk("arst_valid",    32'(out_valid), 32'd0);
    chk("arst_count",    32'(count),     32'd0);
    chk("arst_in_ready", 32'(in_ready),  32'd1);
    @(negedge Clk);
    #1;
    Rst = 1'b1;
    in_valid = 1'b1; in_a = 16'd9; in_b = 16'd4; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_push", 32'(count), 32'd1);
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_rem",   32'(out_rem),   32'd1);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
